mdu_sequencer: RTL and testbench

Multi-cycle controller for the RV32IM M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) in the single-cycle core. Decode identifies an M-type instruction, and the register-file read values then drive this block. It stalls the core through `busy` until the result is ready. It sequences an iterative restoring divider and, by configuration, either an iterative shift-add multiplier or a single-cycle multiplier.

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_iter_step.sv | 30 +++
 rtl/mdu_sequencer.sv | 173 +++++++++++++++++
 tb/tb_mdu_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared state encoding and M-extension decode constants for the MDU sequencer.
package mdu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mdu_state_t;

    localparam logic [6:0] MDU_FUNCT7 = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/mdu_iter_step.sv
// mdu_iter_step: one combinational iteration of restoring divide or shift-add multiply.
module mdu_iter_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [2*XLEN-1:0] sr_i,
    input  logic [XLEN-1:0]   opnd_i,
    input  logic              is_div_i,
    output logic [2*XLEN-1:0] sr_o
);

    logic [XLEN:0] trial;
    logic [XLEN:0] diff;
    logic [XLEN:0] sum;

    // Divide: shift in next dividend bit and subtract when it fits; multiply: add and shift right.
    always_comb begin
        trial = sr_i[2*XLEN-1:XLEN-1];
        diff  = trial - {1'b0, opnd_i};
        sum   = {1'b0, sr_i[2*XLEN-1:XLEN]} + (sr_i[0] ? {1'b0, opnd_i} : (XLEN+1)'(0));
        sr_o  = {sum, sr_i[XLEN-1:1]};
        if (is_div_i) begin
            if (!diff[XLEN]) begin
                sr_o = {diff[XLEN-1:0], sr_i[XLEN-2:0], 1'b1};
            end else begin
                sr_o = {sr_i[2*XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle RV32M multiply/divide controller that stalls the core via busy.
// Build option: define MDU_FAST_MUL_EN for a single-cycle multiplier; default is shift-add.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned FUNCT3_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic [XLEN-1:0]     op_a,
    input  logic [XLEN-1:0]     op_b,
    output logic                busy,
    output logic                done,
    output logic [XLEN-1:0]     result
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FUNCT3_W-1:0] f3_q, f3_d;
    logic [2*XLEN-1:0]   sr_q, sr_d, sr_step;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic                neg_q, neg_d;
    logic                rem_neg_q, rem_neg_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                done_q, done_d;

    logic                is_div, a_signed, b_signed, sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0]     a_mag, b_mag;

    // Final sign fix and half/quotient/remainder select.
    function automatic logic [XLEN-1:0] fix_result(input logic [2*XLEN-1:0] sr,
                                                   input logic [FUNCT3_W-1:0] f3,
                                                   input logic neg, input logic rem_neg);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   q, r, res;
        prod = neg ? -sr : sr;
        q    = sr[XLEN-1:0];
        r    = sr[2*XLEN-1:XLEN];
        if (f3[2]) begin
            res = f3[1] ? (rem_neg ? -r : r) : (neg ? -q : q);
        end else begin
            res = (f3 == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
        return res;
    endfunction

    // Operand signedness, magnitudes and special-case detection.
    always_comb begin
        is_div   = funct3[2];
        a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                   (funct3 == F3_DIV)  || (funct3 == F3_REM);
        b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        sa       = a_signed & op_a[XLEN-1];
        sb       = b_signed & op_b[XLEN-1];
        a_mag    = sa ? -op_a : op_a;
        b_mag    = sb ? -op_b : op_b;
        div_zero = is_div && (op_b == '0);
        div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                   (op_a == INT_MIN) && (op_b == '1);
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0]   fast_res;

    // Single-cycle product of sign-extended operands; low 2*XLEN bits are exact.
    always_comb begin
        fast_prod = {{XLEN{sa}}, op_a} * {{XLEN{sb}}, op_b};
        fast_res  = (funct3 == F3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    mdu_iter_step #(.XLEN(XLEN)) u_step (
        .sr_i     (sr_q),
        .opnd_i   (opnd_q),
        .is_div_i (f3_q[2]),
        .sr_o     (sr_step)
    );

    // Next-state and registered-output logic for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        f3_d      = f3_q;
        sr_d      = sr_q;
        opnd_d    = opnd_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    f3_d      = funct3;
                    neg_d     = sa ^ sb;
                    rem_neg_d = sa;
                    cnt_d     = CNT_W'(XLEN-1);
                    sr_d      = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                    opnd_d    = is_div ? b_mag : a_mag;
                    state_d   = S_RUN;
                    if (div_zero) begin
                        result_d = funct3[1] ? op_a : '1;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = funct3[1] ? '0 : INT_MIN;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end
`ifdef MDU_FAST_MUL_EN
                    else if (!is_div) begin
                        result_d = fast_res;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end
`endif
                end
            end
            S_RUN: begin
                sr_d = sr_step;
                if (cnt_q == '0) begin
                    result_d = fix_result(sr_step, f3_q, neg_q, rem_neg_q);
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            f3_q      <= '0;
            sr_q      <= '0;
            opnd_q    <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            f3_q      <= f3_d;
            sr_q      <= sr_d;
            opnd_q    <= opnd_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    assign busy   = ((state_q == S_IDLE) && start) || (state_q == S_RUN);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed self-checking bench for mdu_sequencer (either multiplier build).
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    mdu_sequencer #(.XLEN(32), .FUNCT3_W(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op at cycle 0, wait for done, check latency/result/busy and result hold.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int  cyc;
        logic seen;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        #1;
        check({tag, " busy_c0"}, 32'(busy), 32'd1);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(cyc), 32'(lat));
        check({tag, " busy_done"}, 32'(busy), 32'd0);
        check({tag, " result"}, result, exp);
        @(posedge clk); #1;
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " result_hold"}, result, exp);
    endtask

    initial begin
        int n_done;
        int c1, c2;
        logic [31:0] r1, r2;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Divide sign rules
        run_op("DIV -7/2",   3'b100, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 33);
        run_op("REM -7/2",   3'b110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 33);
        run_op("DIV 7/-2",   3'b100, 32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 33);
        run_op("REM 7/-2",   3'b110, 32'd7,         32'hFFFF_FFFE,  32'd1,         33);
        run_op("DIVU 100/7", 3'b101, 32'd100,       32'd7,          32'd14,        33);
        run_op("REMU 100/7", 3'b111, 32'd100,       32'd7,          32'd2,         33);

        // Multiplies
        run_op("MULHU",      3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, MUL_LAT);
        run_op("MULH",       3'b001, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, MUL_LAT);
        run_op("MULHSU",     3'b010, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, MUL_LAT);
        run_op("MUL 3*-2",   3'b000, 32'd3,         32'hFFFF_FFFE,  32'hFFFF_FFFA, MUL_LAT);

        // Special cases
        run_op("DIVU 5/0",   3'b101, 32'd5,         32'd0,          32'hFFFF_FFFF, 1);
        run_op("REMU 5/0",   3'b111, 32'd5,         32'd0,          32'd5,         1);
        run_op("REM -7/0",   3'b110, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 1);
        run_op("DIV ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 1);
        run_op("REM ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         1);

        // Reset in the middle of a divide
        funct3 = 3'b100;
        op_a   = 32'hFFFF_FFF9;
        op_b   = 32'd2;
        start  = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("midrun busy", 32'(busy), 32'd1);
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst result", result, 32'd0);
        rst    = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("midrst no_done", 32'(n_done), 32'd0);

        // Back-to-back DIVU with start held across DONE
        funct3 = 3'b101;
        op_a   = 32'd100;
        op_b   = 32'd7;
        start  = 1'b1;
        n_done = 0;
        c1 = 0; c2 = 0; r1 = '0; r2 = '0;
        for (int cyc = 1; cyc <= 90; cyc++) begin
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                if (n_done == 1) begin c1 = cyc; r1 = result; end
                if (n_done == 2) begin c2 = cyc; r2 = result; start = 1'b0; end
            end
        end
        start = 1'b0;
        check("b2b pulses", 32'(n_done), 32'd2);
        check("b2b first_cycle", 32'(c1), 32'd33);
        check("b2b first_result", r1, 32'd14);
        check("b2b second_cycle", 32'(c2), 32'd67);
        check("b2b second_result", r2, 32'd14);
        check("b2b idle_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
